matc_result_reader: RTL and testbench
=====================================

// Module: matc_result_reader
// PURPOSE
//  Read-side companion of the 4x4 matrix multiplier: after the multiplier has written the
//  16 20-bit C results into result RAM, this block fetches them in row-major order.
//  It streams the results out on a valid/ready interface with row/col tags.
//  A 2-entry skid FIFO hides the 1-cycle RAM read latency, giving 1 element/cycle.
// PARAMETERS
//  N       4   matrix dimension (elements = N*N = 16)
//  DATA_W  20  result word width
//  ADDR_W  9   result RAM address width
// PORTS
//  clock     in   1       single clock, rising edge
//  rst_n     in   1       asynchronous, active-low reset
//  go        in   1       1-cycle start pulse (multiplier done); ignored while busy
//  base_addr in   ADDR_W  RAM address of C[0][0], sampled on accepted go
//  ram_rden  out  1       RAM read enable
//  ram_addr  out  ADDR_W  RAM read address
//  ram_q     in   DATA_W  RAM read data, valid 1 cycle after ram_rden
//  m_valid   out  1       output element valid
//  m_ready   in   1       downstream accept
//  m_data    out  DATA_W  C[row][col]
//  m_row     out  2       row index
//  m_col     out  2       column index
//  m_last    out  1       high with element 15 (C[3][3])
//  busy      out  1       high from accepted go until done
//  done      out  1       1-cycle pulse after last handshake
//  checksum  out  DATA_W  XOR of delivered words (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE; an assertion mid-transfer aborts it, no done.
//  FSM: IDLE -go-> READ (issue 16 reads) -16th issued-> DRAIN -16th handshake-> DONE -> IDLE.
//  Address: ram_addr = base_addr + row*N + col, modulo 2^ADDR_W (wraps past top).
//  Read issue: in READ, ram_rden=1 iff fifo_count + inflight - pop < 2 (pop = m_valid&m_ready).
//  Handshake: element transfers on m_valid&&m_ready; m_data/m_row/m_col/m_last held stable while m_valid&&!m_ready.
//  Latency: go at edge 0 -> ram_rden cycle 1 -> m_valid cycle 3; with m_ready=1, elements
//   on cycles 3..18, m_last on cycle 18, done and busy falling on cycle 19.
//  Backpressure: m_ready low any length -> no loss/duplication; reads stall, resume on ready.
//  go while busy: ignored, base_addr not resampled. go coincident with done cycle: ignored.
//  m_valid never asserted in IDLE; m_last only with m_valid.
// CONFIGURATION
//  MATC_CHECKSUM_EN defined: checksum cleared on accepted go, XORed with m_data on each
//   handshake; final value stable from done until next accepted go.
//  Not defined: checksum tied to 0, no XOR logic.
// STRUCTURE
//  Shared package matmul_pkg: N, DATA_W, ADDR_W, FSM state encodings, 2-bit row/col index type.
//  Sub-module matc_skid_fifo: 2-entry FIFO carrying {last,row,col,data}; count, push, pop.
// TESTING
//  1 RAM 0..15 = 0x100+i, base 0, m_ready=1, go -> 16 elements 0x100..0x10F on cycles 3..18, last on 18, done 19.
//  2 Multiplier result (A=0..15, B=10..25 row-major) at base 32 -> first element C[0][0]=116 at (0,0), addr 32..47 read.
//  3 m_ready toggled 1/0 every cycle plus 10-cycle stall mid-stream -> identical sequence, data stable while stalled.
//  4 base_addr=510 -> ram_addr 510,511,0,...,13; 16 correct elements.
//  5 rst_n low after 5th handshake -> outputs 0 at once; new go -> full clean 16-element transfer.
//  6 MATC_CHECKSUM_EN, data of 1 -> checksum 0x00000; data 0..15 = i*i -> checksum = XOR of squares; 2nd go while busy ignored.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the 4x4 matrix multiplier result path: sizes, FSM
// encoding and the element record carried through the result reader.
package matmul_pkg;

  localparam int N      = 4;
  localparam int DATA_W = 20;
  localparam int ADDR_W = 9;
  localparam int ELEMS  = N * N;

  typedef logic [1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic              last;
    idx_t              row;
    idx_t              col;
    logic [DATA_W-1:0] data;
  } elem_t;

  localparam int ELEM_W = $bits(elem_t);

endpackage

// File: rtl/matc_skid_fifo.sv
// Two-entry FIFO holding {last,row,col,data} records between the RAM read
// port and the output handshake; the head entry drives the stream directly.
module matc_skid_fifo
  import matmul_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ELEM_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [1:0]        count_o,
  output logic [ELEM_W-1:0] head_o
);

  logic [ELEM_W-1:0] mem0_q;
  logic [ELEM_W-1:0] mem1_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  // Storage, pointers and occupancy; the caller guarantees no overflow/underflow.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q   <= {ELEM_W{1'b0}};
      mem1_q   <= {ELEM_W{1'b0}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i && !wr_ptr_q) mem0_q <= push_data_i;
      else                     mem0_q <= mem0_q;
      if (push_i && wr_ptr_q)  mem1_q <= push_data_i;
      else                     mem1_q <= mem1_q;
      wr_ptr_q <= wr_ptr_q ^ push_i;
      rd_ptr_q <= rd_ptr_q ^ pop_i;
      count_q  <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign count_o = count_q;
  assign head_o  = rd_ptr_q ? mem1_q : mem0_q;

endmodule

// File: rtl/matc_result_reader.sv
// Streams the 16 C results out of result RAM in row-major order, one per cycle.
// Optional MATC_CHECKSUM_EN adds an XOR checksum of the delivered words.
module matc_result_reader
  import matmul_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              ram_rden,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        m_row,
  output logic [1:0]        m_col,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [3:0]        rd_idx_q;
  logic [3:0]        tag_idx_q;
  logic              inflight_q;
  logic              busy_q;
  logic              done_q;

  logic              go_acc_s;
  logic              rden_s;
  logic              pop_s;
  logic [2:0]        occ_s;
  logic [1:0]        fifo_count_s;
  elem_t             head_s;
  elem_t             push_elem_s;

  assign go_acc_s = (state_q == ST_IDLE) && go;
  assign m_valid  = (fifo_count_s != 2'd0);
  assign pop_s    = m_valid && m_ready;
  // Slots already committed: buffered plus in flight, minus the one leaving now.
  assign occ_s    = {1'b0, fifo_count_s} + {2'b00, inflight_q} - {2'b00, pop_s};

  // Next state and read issue.
  always_comb begin
    state_d = state_q;
    rden_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_READ;
        else    state_d = ST_IDLE;
      end
      ST_READ: begin
        rden_s = (occ_s < 3'd2);
        if (rden_s && (rd_idx_q == 4'd15)) state_d = ST_DRAIN;
        else                               state_d = ST_READ;
      end
      ST_DRAIN: begin
        if (pop_s && head_s.last) state_d = ST_DONE;
        else                      state_d = ST_DRAIN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, read pointer, in-flight tag and status flags.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= {ADDR_W{1'b0}};
      rd_idx_q   <= 4'd0;
      tag_idx_q  <= 4'd0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= go_acc_s ? base_addr : base_q;
      if (go_acc_s)    rd_idx_q <= 4'd0;
      else if (rden_s) rd_idx_q <= rd_idx_q + 4'd1;
      else             rd_idx_q <= rd_idx_q;
      tag_idx_q  <= rden_s ? rd_idx_q : tag_idx_q;
      inflight_q <= rden_s;
      busy_q     <= (state_d == ST_READ) || (state_d == ST_DRAIN);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign ram_rden = rden_s;
  assign ram_addr = base_q + {{(ADDR_W-4){1'b0}}, rd_idx_q};

  assign push_elem_s.last = (tag_idx_q == 4'd15);
  assign push_elem_s.row  = tag_idx_q[3:2];
  assign push_elem_s.col  = tag_idx_q[1:0];
  assign push_elem_s.data = ram_q;

  matc_skid_fifo u_fifo (
    .clock       (clock),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (push_elem_s),
    .pop_i       (pop_s),
    .count_o     (fifo_count_s),
    .head_o      (head_s)
  );

  // Payload is forced to zero whenever nothing is offered.
  assign m_data = m_valid ? head_s.data : {DATA_W{1'b0}};
  assign m_row  = m_valid ? head_s.row  : 2'd0;
  assign m_col  = m_valid ? head_s.col  : 2'd0;
  assign m_last = m_valid && head_s.last;
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef MATC_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  // Running XOR of delivered words, cleared when a new transfer starts.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)        checksum_q <= {DATA_W{1'b0}};
    else if (go_acc_s) checksum_q <= {DATA_W{1'b0}};
    else if (pop_s)    checksum_q <= checksum_q ^ head_s.data;
    else               checksum_q <= checksum_q;
  end

  assign checksum = checksum_q;
`else
  assign checksum = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_matc_result_reader.sv
// Directed bench for matc_result_reader: behavioural RAM, scoreboard of expected
// addresses and elements, latency/backpressure/wrap/reset/checksum checks.
module tb_matc_result_reader;

  logic        clock = 1'b0;
  logic        rst_n, go, m_ready;
  logic [8:0]  base_addr;
  logic        ram_rden;
  logic [8:0]  ram_addr;
  logic [19:0] ram_q;
  logic        m_valid;
  logic [19:0] m_data;
  logic [1:0]  m_row, m_col;
  logic        m_last, busy, done;
  logic [19:0] checksum;

  always #5 clock = ~clock;

  matc_result_reader dut (
    .clock(clock), .rst_n(rst_n), .go(go), .base_addr(base_addr),
    .ram_rden(ram_rden), .ram_addr(ram_addr), .ram_q(ram_q),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_row(m_row), .m_col(m_col), .m_last(m_last),
    .busy(busy), .done(done), .checksum(checksum)
  );

  logic [19:0] mem [512];
  always @(posedge clock) if (ram_rden) ram_q <= mem[ram_addr];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [24:0] exp_q  [$];
  logic [8:0]  addr_q [$];
  logic [19:0] exp_xor;
  int          cyc, hs_cnt, first_hs, last_hs, done_cyc, busy_bad;
  logic [19:0] first_data;
  logic        busy_at_done, done_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_expect(input logic [8:0] b);
    exp_xor = 20'd0;
    for (int i = 0; i < 16; i++) begin
      logic [8:0] a;
      logic [3:0] ii;
      a  = b + 9'(i);
      ii = 4'(i);
      addr_q.push_back(a);
      exp_q.push_back({(ii == 4'd15), ii[3:2], ii[1:0], mem[a]});
      exp_xor = exp_xor ^ mem[a];
    end
  endtask

  task automatic start(input logic [8:0] b);
    base_addr = b;
    go = 1'b1;
    load_expect(b);
    @(posedge clock); #1;
    go = 1'b0;
    base_addr = 9'h1AB;
  endtask

  // mode 0: always ready; mode 1: toggling ready plus a 10-cycle stall.
  task automatic run(input int max_cyc, input int mode, input int stop_hs,
                     input bit go_busy, input bit go_done);
    logic        held_v;
    logic [24:0] held, obs;
    logic [31:0] e;
    cyc = 0; hs_cnt = 0; first_hs = -1; last_hs = -1; done_cyc = -1;
    busy_bad = 0; held_v = 1'b0; held = 25'd0; done_seen = 1'b0; busy_at_done = 1'b1;
    while (!done_seen && cyc < max_cyc && !(stop_hs > 0 && hs_cnt >= stop_hs)) begin
      cyc++;
      if (mode == 1) m_ready = (cyc >= 20 && cyc < 30) ? 1'b0 : ((cyc % 2) == 1);
      else           m_ready = 1'b1;
      if (go_busy && cyc == 5) begin go = 1'b1; base_addr = 9'd300; end
      @(negedge clock);
      obs = {m_last, m_row, m_col, m_data};
      if (held_v) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_payload", 32'(obs), 32'(held));
      end
      held_v = m_valid && !m_ready;
      held   = obs;
      if (m_last && !m_valid) chk("last_without_valid", 32'(m_valid), 32'd1);
      if (ram_rden) begin
        e = (addr_q.size() > 0) ? 32'(addr_q.pop_front()) : 32'hFFFF_FFFF;
        chk("ram_addr", 32'(ram_addr), e);
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (first_hs < 0) begin first_hs = cyc; first_data = m_data; end
        last_hs = cyc;
        e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
        chk("element", 32'(obs), e);
      end
      if (done) begin
        done_seen = 1'b1; done_cyc = cyc; busy_at_done = busy;
        if (go_done) go = 1'b1;
      end else if (!busy) begin
        busy_bad++;
      end
      @(posedge clock); #1;
      go = 1'b0;
    end
    if (stop_hs == 0) begin
      chk("done_seen", 32'(done_seen), 32'd1);
      chk("sb_elems_left", 32'(exp_q.size()), 32'd0);
      chk("sb_addrs_left", 32'(addr_q.size()), 32'd0);
      chk("busy_at_done", 32'(busy_at_done), 32'd0);
      chk("busy_gaps", 32'(busy_bad), 32'd0);
    end
  endtask

  task automatic check_latency(input string tag);
    chk({tag, "_first_hs"}, 32'(first_hs), 32'd3);
    chk({tag, "_last_hs"}, 32'(last_hs), 32'd18);
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'd19);
  endtask

  task automatic check_checksum(input string tag);
`ifdef MATC_CHECKSUM_EN
    chk(tag, 32'(checksum), 32'(exp_xor));
`else
    chk(tag, 32'(checksum), 32'd0);
`endif
  endtask

  initial begin
    int s;
    rst_n = 1'b0; go = 1'b0; m_ready = 1'b0; base_addr = 9'd0;
    for (int i = 0; i < 512; i++) mem[i] = 20'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rden", 32'(ram_rden), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    rst_n = 1'b1;
    @(posedge clock); #1;

    // 1: basic stream, full throughput
    for (int i = 0; i < 16; i++) mem[i] = 20'h100 + 20'(i);
    start(9'd0);
    run(60, 0, 0, 1'b0, 1'b0);
    check_latency("t1");
    chk("t1_idle_valid", 32'(m_valid), 32'd0);

    // 2: real multiplier result at base 32; go coincident with done ignored
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += (i * 4 + k) * (10 + k * 4 + j);
        mem[32 + i * 4 + j] = 20'(s);
      end
    start(9'd32);
    run(60, 0, 0, 1'b0, 1'b1);
    chk("t2_c00", 32'(first_data), 32'd116);
    @(negedge clock);
    chk("t2_go_in_done_busy", 32'(busy), 32'd0);
    chk("t2_go_in_done_rden", 32'(ram_rden), 32'd0);
    @(posedge clock); #1;

    // 3: toggling ready and a long stall
    for (int i = 0; i < 16; i++) mem[i] = 20'h5A000 ^ 20'(i * 273);
    start(9'd0);
    run(200, 1, 0, 1'b0, 1'b0);

    // 4: address wrap past the top of RAM
    for (int i = 0; i < 16; i++) mem[(510 + i) % 512] = 20'h30000 + 20'(i * 7);
    start(9'd510);
    run(60, 0, 0, 1'b0, 1'b0);
    check_latency("t4");

    // 5: reset mid-transfer, then a clean transfer
    for (int i = 0; i < 16; i++) mem[i] = 20'h100 + 20'(i);
    start(9'd0);
    run(60, 0, 5, 1'b0, 1'b0);
    chk("t5_hs_before_reset", 32'(hs_cnt), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(m_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    chk("t5_rst_rden", 32'(ram_rden), 32'd0);
    chk("t5_rst_data", 32'(m_data), 32'd0);
    exp_q.delete();
    addr_q.delete();
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(posedge clock); #1;
    start(9'd0);
    run(60, 0, 0, 1'b0, 1'b0);
    check_latency("t5");

    // 6: checksum, with a go while busy that must be ignored
    for (int i = 0; i < 16; i++) mem[64 + i] = 20'd1;
    start(9'd64);
    run(60, 0, 0, 1'b1, 1'b0);
    check_checksum("t6_checksum_ones");
    for (int i = 0; i < 16; i++) mem[64 + i] = 20'(i * i);
    start(9'd64);
    run(60, 0, 0, 1'b1, 1'b0);
    check_checksum("t6_checksum_squares");
    repeat (2) @(posedge clock);
    #1;
    check_checksum("t6_checksum_stable");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
